// File: rtl/result_reader_pkg.sv
// Shared constants and FSM encoding for the result SRAM reader and the
// write-back stage.
package result_reader_pkg;

    localparam int unsigned RESULT_W = 18;
    localparam int unsigned RAM_AW   = 8;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StWait = 3'd2,
        StSend = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/result_stats.sv
// Frame statistics: running maximum, index of the first maximum, and sum of
// every sampled value. Cleared at frame start, held until the next clear.
module result_stats #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                sample,
    input  logic [DATA_W-1:0]   value,
    input  logic [IDX_W-1:0]    idx,
    output logic [DATA_W-1:0]   max_val,
    output logic [IDX_W-1:0]    max_idx,
    output logic [DATA_W+7:0]   sum
);

    localparam int unsigned SumW = DATA_W + 8;

    logic [DATA_W-1:0] max_val_q, max_val_d;
    logic [IDX_W-1:0]  max_idx_q, max_idx_d;
    logic [SumW-1:0]   sum_q, sum_d;

    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        sum_d     = sum_q;
        if (clear) begin
            max_val_d = '0;
            max_idx_d = '0;
            sum_d     = '0;
        end else if (sample) begin
            sum_d = sum_q + SumW'(value);
            // Strict compare keeps the earliest index on ties.
            if (idx == '0 || value > max_val_q) begin
                max_val_d = value;
                max_idx_d = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val_q <= '0;
            max_idx_q <= '0;
            sum_q     <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            sum_q     <= sum_d;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;
    assign sum     = sum_q;

endmodule

// File: rtl/result_reader.sv
// Reads one frame of results from the result SRAM on start and streams each
// word over valid/ready, accumulating max, argmax and sum for the host.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DATA_W    = RESULT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                ram_cs_n,
    output logic                ram_we_n,
    output logic [RAM_AW-1:0]   ram_addr,
    input  logic [31:0]         ram_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   max_val,
    output logic [RAM_AW-1:0]   max_idx,
    output logic [DATA_W+7:0]   sum
);

    localparam logic [RAM_AW-1:0] LastIdx  = RAM_AW'(NUM_WORDS - 1);
    localparam logic [RAM_AW-1:0] BaseAddr = RAM_AW'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [RAM_AW-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              stats_clear;
    logic              xfer;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        stats_clear = 1'b0;
        xfer        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d       = '0;
                    stats_clear = 1'b1;
                    state_d     = StRd;
                end
            end
            StRd: begin
                state_d = StWait;
            end
            StWait: begin
                // Read data is valid exactly one cycle after the select.
                out_data_d  = ram_rdata[DATA_W-1:0];
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LastIdx);
                state_d     = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    xfer        = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRd;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    result_stats #(
        .DATA_W (DATA_W),
        .IDX_W  (RAM_AW)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .clear   (stats_clear),
        .sample  (xfer),
        .value   (out_data_q),
        .idx     (idx_q),
        .max_val (max_val),
        .max_idx (max_idx),
        .sum     (sum)
    );

    if (DATA_W < 32) begin : g_unused
        logic unused_rdata_hi;
        assign unused_rdata_hi = ^ram_rdata[31:DATA_W];
    end

    assign ram_cs_n  = (state_q != StRd);
    assign ram_we_n  = 1'b1;
    assign ram_addr  = (state_q == StRd) ? (BaseAddr + idx_q) : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == StRd) || (state_q == StWait) || (state_q == StSend);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_result_reader.sv
// Directed-plus-random bench for result_reader with a behavioural SRAM and a
// frame-level reference model of the streamed words and statistics.
module tb_result_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready;
    logic        ram_cs_n, ram_we_n;
    logic [7:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic        out_valid, out_last, busy, done;
    logic [17:0] out_data, max_val;
    logic [7:0]  max_idx;
    logic [25:0] sum;

    logic        start1, out_ready1;
    logic        ram_cs_n1, ram_we_n1;
    logic [7:0]  ram_addr1;
    logic [31:0] ram_rdata1;
    logic        out_valid1, out_last1, busy1, done1;
    logic [17:0] out_data1, max_val1;
    logic [7:0]  max_idx1;
    logic [25:0] sum1;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    result_reader #(.NUM_WORDS(16), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .max_val(max_val), .max_idx(max_idx), .sum(sum)
    );

    result_reader #(.NUM_WORDS(1), .BASE_ADDR(200)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .ram_cs_n(ram_cs_n1), .ram_we_n(ram_we_n1), .ram_addr(ram_addr1), .ram_rdata(ram_rdata1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1), .done(done1), .max_val(max_val1),
        .max_idx(max_idx1), .sum(sum1)
    );

    // SRAM: data only meaningful one cycle after a select, garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_rdata  <= !ram_cs_n  ? mem[ram_addr]  : $urandom;
        ram_rdata1 <= !ram_cs_n1 ? mem[ram_addr1] : $urandom;
    end

    logic [17:0] rx_data[$];
    logic        rx_last[$];
    logic [7:0]  rx_addr[$];
    int          cs_cyc[$], vrise_cyc[$], xfer_cyc[$], done_cyc[$];
    logic [17:0] rx1_data[$];
    logic        rx1_last[$];
    logic [7:0]  rx1_addr[$];
    int done_cnt = 0, done1_cnt = 0, cs_viol = 0, hold_viol = 0, we_viol = 0;
    logic        prev_valid = 1'b0, hold_pend = 1'b0, hold_last = 1'b0;
    logic [17:0] hold_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!ram_cs_n) begin
                rx_addr.push_back(ram_addr);
                cs_cyc.push_back(cyc);
            end
            if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                xfer_cyc.push_back(cyc);
            end
            if (!ram_cs_n && out_valid) cs_viol <= cs_viol + 1;
            if (hold_pend && (!out_valid || out_data !== hold_data || out_last !== hold_last))
                hold_viol <= hold_viol + 1;
            if (!ram_cs_n1) rx1_addr.push_back(ram_addr1);
            if (out_valid1 && out_ready1) begin
                rx1_data.push_back(out_data1);
                rx1_last.push_back(out_last1);
            end
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc.push_back(cyc);
        end
        if (done1) done1_cnt <= done1_cnt + 1;
        if (ram_we_n !== 1'b1 || ram_we_n1 !== 1'b1) we_viol <= we_viol + 1;
        prev_valid <= out_valid;
        hold_pend  <= !rst && out_valid && !out_ready;
        hold_data  <= out_data;
        hold_last  <= out_last;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame reference: words are the low 18 bits of consecutive SRAM entries.
    task automatic ref_stats(input int base, input int n, output logic [17:0] mx,
                             output logic [7:0] mi, output logic [25:0] sm);
        int unsigned v, best, bi;
        longint total;
        best = 0; bi = 0; total = 0;
        for (int k = 0; k < n; k++) begin
            v = mem[base + k] & 32'h3FFFF;
            if (k == 0 || v > best) begin
                best = v;
                bi = k;
            end
            total += v;
        end
        mx = 18'(best);
        mi = 8'(bi);
        sm = 26'(total);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_cs_n"}, ram_cs_n, 1'b1);
        chk({tag, "_we_n"}, ram_we_n, 1'b1);
        chk({tag, "_addr"}, ram_addr, 8'h0);
        chk({tag, "_data"}, out_data, 18'h0);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_maxv"}, max_val, 18'h0);
        chk({tag, "_maxi"}, max_idx, 8'h0);
        chk({tag, "_sum"}, sum, 26'h0);
    endtask

    int frame_st, frame_d0;

    // mode 0: ready high; 1: ready low 5 cycles on word 3; 2: random ready.
    task automatic run_frame(input string tag, input int mode, input bit mid_start,
                             input bit done_start);
        bit fin, injected;
        int stall;
        fin = 0; injected = 0; stall = 0;
        rx_data.delete(); rx_last.delete(); rx_addr.delete();
        cs_cyc.delete(); vrise_cyc.delete(); xfer_cyc.delete(); done_cyc.delete();
        frame_d0 = done_cnt;
        start = 1'b1;
        frame_st = cyc;
        tick();
        for (int c = 0; c < 2000 && !fin; c++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if (rx_data.size() == 3 && out_valid && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = 1'b0;
            if (mid_start && !injected && rx_data.size() == 5) begin
                start = 1'b1;
                injected = 1;
            end
            tick();
            if (done) begin
                fin = 1;
                if (done_start) begin
                    start = 1'b1;
                    tick();
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_completed"}, fin, 1'b1);
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag, input int n);
        logic [17:0] emx;
        logic [7:0]  emi;
        logic [25:0] esm;
        int addr_bad;
        addr_bad = 0;
        chk({tag, "_nwords"}, rx_data.size(), n);
        for (int k = 0; k < n && k < rx_data.size(); k++) begin
            chk($sformatf("%s_w%0d", tag, k), rx_data[k], mem[k] & 32'h3FFFF);
            chk($sformatf("%s_last%0d", tag, k), rx_last[k], k == n - 1);
        end
        for (int k = 0; k < rx_addr.size(); k++) if (rx_addr[k] != 8'(k)) addr_bad++;
        chk({tag, "_nreads"}, rx_addr.size(), n);
        chk({tag, "_addr_seq"}, addr_bad, 0);
        chk({tag, "_done_cnt"}, done_cnt - frame_d0, 1);
        ref_stats(0, n, emx, emi, esm);
        chk({tag, "_max_val"}, max_val, emx);
        chk({tag, "_max_idx"}, max_idx, emi);
        chk({tag, "_sum"}, sum, esm);
    endtask

    initial begin
        bit fin;
        int d1;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; out_ready1 = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        tick();
        tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // Reset while a word is waiting in SEND.
        frame_d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        chk("rst_reached_send", out_valid, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset("rst_mid");
        repeat (5) tick();
        chk("rst_no_done", done_cnt - frame_d0, 0);
        chk("rst_stays_idle", busy, 1'b0);

        // Basic frame with ready held high.
        for (int k = 0; k < 16; k++) mem[k] = 32'(k * 10);
        run_frame("basic", 0, 0, 0);
        check_frame("basic", 16);
        chk("basic_first_cs", cs_cyc.size() > 0 ? cs_cyc[0] - frame_st : -1, 1);
        chk("basic_first_valid", vrise_cyc.size() > 0 ? vrise_cyc[0] - frame_st : -1, 3);
        chk("basic_throughput", xfer_cyc.size() == 16 ? xfer_cyc[15] - xfer_cyc[0] : -1, 45);
        chk("basic_done_lat",
            (done_cyc.size() > 0 && xfer_cyc.size() > 0) ?
            done_cyc[done_cyc.size() - 1] - xfer_cyc[xfer_cyc.size() - 1] : -1, 1);
        chk("basic_max_const", max_val, 18'd150);
        chk("basic_idx_const", max_idx, 8'd15);
        chk("basic_sum_const", sum, 26'd1200);

        // Backpressure on word 3.
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        run_frame("stall", 1, 0, 0);
        check_frame("stall", 16);
        chk("stall_gap", xfer_cyc.size() == 16 ? xfer_cyc[3] - xfer_cyc[2] : -1, 8);

        // Equal maxima and junk in the upper bits.
        for (int k = 0; k < 16; k++) mem[k] = 32'hFFFC0005;
        mem[2] = 32'hFFFFFFFF;
        mem[9] = 32'hFFFFFFFF;
        run_frame("tie", 2, 0, 0);
        check_frame("tie", 16);
        chk("tie_max_const", max_val, 18'h3FFFF);
        chk("tie_idx_const", max_idx, 8'd2);
        chk("tie_sum_const", sum, 26'(2 * 32'h3FFFF + 14 * 5));

        // Starts while busy and in DONE must be ignored.
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        run_frame("ign", 0, 1, 1);
        check_frame("ign", 16);
        chk("ign_no_second_frame", busy, 1'b0);

        // A fresh frame must clear the previous statistics.
        for (int k = 0; k < 16; k++) mem[k] = $urandom_range(0, 1000);
        run_frame("second", 2, 0, 0);
        check_frame("second", 16);

        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++)
                mem[k] = (f == 0) ? $urandom_range(0, 3) : $urandom;
            run_frame($sformatf("rand%0d", f), 2, 0, 0);
            check_frame($sformatf("rand%0d", f), 16);
        end

        // Single-word frame at a non-zero base.
        mem[200] = $urandom;
        rx1_data.delete(); rx1_last.delete(); rx1_addr.delete();
        d1 = done1_cnt;
        fin = 0;
        start1 = 1'b1;
        out_ready1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            tick();
            if (done1) fin = 1;
        end
        chk("n1_completed", fin, 1'b1);
        repeat (2) tick();
        chk("n1_nreads", rx1_addr.size(), 1);
        if (rx1_addr.size() > 0) chk("n1_addr", rx1_addr[0], 8'd200);
        chk("n1_nwords", rx1_data.size(), 1);
        if (rx1_data.size() > 0) begin
            chk("n1_data", rx1_data[0], mem[200] & 32'h3FFFF);
            chk("n1_last", rx1_last[0], 1'b1);
        end
        chk("n1_done_cnt", done1_cnt - d1, 1);
        chk("n1_max_val", max_val1, mem[200] & 32'h3FFFF);
        chk("n1_max_idx", max_idx1, 8'd0);
        chk("n1_sum", sum1, mem[200] & 32'h3FFFF);

        chk("no_cs_while_valid", cs_viol, 0);
        chk("held_while_stalled", hold_viol, 0);
        chk("never_writes", we_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
